display_fetch: RTL and testbench
================================

DISPLAY_FETCH -- requirements
Module: display_fetch

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 12, pixel width.
REQ-002 SHALL have parameter FILL_WIDTH, default 10, FIFO fill-count width.
REQ-003 SHALL have parameter PRIME_LEVEL, default 640, minimum FIFO fill before scan-out starts.
REQ-004 SHALL have port i_clk  input  1  pixel clock, one clock domain, all logic on rising edge.
REQ-005 SHALL have port i_rstn  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port i_flush  input  1  synchronous flush, active-high.
REQ-007 SHALL have port i_en  input  1  scan-out enable, level.
REQ-008 SHALL have port o_req  output  1  one-cycle frame request pulse to the frame-buffer reader.
REQ-009 SHALL have port o_rd  output  1  FIFO read strobe; data valid one cycle later.
REQ-010 SHALL have port i_rdata  input  DATA_WIDTH  FIFO read data.
REQ-011 SHALL have port i_empty  input  1  FIFO empty flag.
REQ-012 SHALL have port i_rfill  input  FILL_WIDTH  FIFO fill count.
REQ-013 SHALL have port o_hsync  output  1  horizontal sync, active-low.
REQ-014 SHALL have port o_vsync  output  1  vertical sync, active-low.
REQ-015 SHALL have port o_de  output  1  active-video data enable.
REQ-016 SHALL have port o_rgb  output  DATA_WIDTH  pixel out.
REQ-017 SHALL have port o_underflow  output  1  sticky underflow flag.

Function
REQ-018 SHALL implement FSM states IDLE, PRIME, RUN.
REQ-019 IDLE: counters held at 0; i_en=1 -> PRIME, with o_req=1 for exactly the transition cycle.
REQ-020 PRIME: wait until i_rfill >= PRIME_LEVEL, then -> RUN with hcount=0, vcount=0; i_en=0 in PRIME -> IDLE.
REQ-021 RUN: hcount 0..799, wraps to 0 and increments vcount; vcount 0..524, wraps to 0 (640x480 @ 800x525 total).
REQ-022 Active region: hcount<640 and vcount<480.
REQ-023 Sync: hsync low for hcount 656..751; vsync low for vcount 490..491; otherwise high.
REQ-024 o_rd SHALL be combinational: 1 iff state=RUN, active region, and i_empty=0.
REQ-025 o_hsync, o_vsync, o_de SHALL be registered from the counters, 1 cycle after, aligned with i_rdata of the matching o_rd.
REQ-026 o_rgb SHALL equal i_rdata when o_de=1 and the matching read occurred, else 0.
REQ-027 Underflow: active-region cycle with i_empty=1 -> no read, o_rgb=0 for that pixel, o_underflow set next cycle and held.
REQ-028 o_req SHALL pulse 1 cycle in RUN at hcount=0, vcount=480, to request the next frame.
REQ-029 i_en deasserted in RUN SHALL take effect only at frame end (hcount=799, vcount=524) -> IDLE; otherwise continue.
REQ-030 At frame end with i_en=1, RUN SHALL continue into the next frame without re-priming.
REQ-031 i_flush=1 SHALL have priority over all events: next cycle state=IDLE, counters 0, outputs at reset values, o_underflow cleared.
REQ-032 Outside RUN: o_rd=0, o_de=0, o_hsync=1, o_vsync=1, o_rgb=0.

Reset
REQ-033 i_rstn=0 SHALL asynchronously force state=IDLE, counters 0, o_req=0, o_de=0, o_rgb=0, o_hsync=1, o_vsync=1, o_underflow=0; o_rd=0 follows.
REQ-034 Reset mid-frame SHALL abandon the frame; after release the block restarts from IDLE and needs i_en to issue a new o_req.

Verification
REQ-035 Reset release, i_en=1, model FIFO filled to 640 after 100 cycles -> one o_req pulse, RUN entered, first o_de=1 one cycle after entry.
REQ-036 Full frame, FIFO never empty -> 307200 o_rd strobes, 480 lines of 640 o_de cycles, hsync low 96 cycles/line, vsync low 2 lines, o_req at (0,480).
REQ-037 FIFO forced empty for 5 active cycles on line 10 -> 5 black pixels, o_rd=0 those cycles, o_underflow=1 and held.
REQ-038 i_flush during RUN at hcount=300 -> next cycle IDLE, syncs high, o_underflow=0, no further o_rd.
REQ-039 i_en dropped at line 100 -> frame completes to (799,524), then IDLE; no o_rd in the next 1000 cycles.
REQ-040 Async i_rstn pulse between clock edges mid-line -> outputs reach reset values before the next edge.

Source files
------------

// File: rtl/display_fetch.sv
// ============================================================================
// Module      : display_fetch
// Description : Scan-out controller that drains a pixel FIFO into a
//               640x480 (800x525 total) video timing stream. It requests a
//               frame from the frame-buffer reader, waits for the FIFO to
//               prime, then generates sync/DE and reads one pixel per active
//               cycle. A FIFO underflow is flagged stickily.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   i_clk        in   pixel clock, all logic on rising edge
//   i_rstn       in   asynchronous active-low reset
//   i_flush      in   synchronous flush back to IDLE, active-high
//   i_en         in   scan-out enable (level)
//   o_req        out  one-cycle frame request pulse
//   o_rd         out  FIFO read strobe (combinational), data one cycle later
//   i_rdata      in   FIFO read data
//   i_empty      in   FIFO empty flag
//   i_rfill      in   FIFO fill count
//   o_hsync      out  horizontal sync, active-low
//   o_vsync      out  vertical sync, active-low
//   o_de         out  active-video data enable
//   o_rgb        out  pixel out, zero outside valid pixels
//   o_underflow  out  sticky underflow flag
// ============================================================================
`default_nettype none

module display_fetch #(
    parameter int DATA_WIDTH  = 12,
    parameter int FILL_WIDTH  = 10,
    parameter int PRIME_LEVEL = 640,
    parameter int H_ACTIVE    = 640,
    parameter int H_FRONT     = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BACK      = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FRONT     = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BACK      = 33
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic                  i_flush,
    input  logic                  i_en,
    output logic                  o_req,
    output logic                  o_rd,
    input  logic [DATA_WIDTH-1:0] i_rdata,
    input  logic                  i_empty,
    input  logic [FILL_WIDTH-1:0] i_rfill,
    output logic                  o_hsync,
    output logic                  o_vsync,
    output logic                  o_de,
    output logic [DATA_WIDTH-1:0] o_rgb,
    output logic                  o_underflow
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int HCW     = $clog2(H_TOTAL + 1);
    localparam int VCW     = $clog2(V_TOTAL + 1);

    localparam logic [HCW-1:0] H_LAST   = HCW'(H_TOTAL - 1);
    localparam logic [HCW-1:0] H_ACT    = HCW'(H_ACTIVE);
    localparam logic [HCW-1:0] HS_BEGIN = HCW'(H_ACTIVE + H_FRONT);
    localparam logic [HCW-1:0] HS_END   = HCW'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [VCW-1:0] V_LAST   = VCW'(V_TOTAL - 1);
    localparam logic [VCW-1:0] V_ACT    = VCW'(V_ACTIVE);
    localparam logic [VCW-1:0] V_REQ    = VCW'(V_ACTIVE - 1);
    localparam logic [VCW-1:0] VS_BEGIN = VCW'(V_ACTIVE + V_FRONT);
    localparam logic [VCW-1:0] VS_END   = VCW'(V_ACTIVE + V_FRONT + V_SYNC);
    localparam logic [FILL_WIDTH-1:0] PRIME_FILL = FILL_WIDTH'(PRIME_LEVEL);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } state_t;

    state_t          r_state;
    logic [HCW-1:0]  r_hcount;
    logic [VCW-1:0]  r_vcount;
    logic            r_req;
    logic            r_de;
    logic            r_hsync;
    logic            r_vsync;
    logic            r_rd_d;
    logic            r_underflow;

    logic            w_active;
    logic            w_rd;
    logic            w_hsync;
    logic            w_vsync;

    assign w_active = (r_state == RUN) && (r_hcount < H_ACT) && (r_vcount < V_ACT);
    assign w_rd     = w_active && !i_empty;
    assign w_hsync  = !((r_hcount >= HS_BEGIN) && (r_hcount < HS_END));
    assign w_vsync  = !((r_vcount >= VS_BEGIN) && (r_vcount < VS_END));

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state     <= IDLE;
            r_hcount    <= '0;
            r_vcount    <= '0;
            r_req       <= 1'b0;
            r_de        <= 1'b0;
            r_hsync     <= 1'b1;
            r_vsync     <= 1'b1;
            r_rd_d      <= 1'b0;
            r_underflow <= 1'b0;
        end else if (i_flush) begin
            r_state     <= IDLE;
            r_hcount    <= '0;
            r_vcount    <= '0;
            r_req       <= 1'b0;
            r_de        <= 1'b0;
            r_hsync     <= 1'b1;
            r_vsync     <= 1'b1;
            r_rd_d      <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            // Idle-looking video outputs unless the RUN branch overrides them.
            r_req   <= 1'b0;
            r_de    <= 1'b0;
            r_hsync <= 1'b1;
            r_vsync <= 1'b1;
            r_rd_d  <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_hcount <= '0;
                    r_vcount <= '0;
                    if (i_en) begin
                        r_state <= PRIME;
                        r_req   <= 1'b1;
                    end
                end
                PRIME: begin
                    r_hcount <= '0;
                    r_vcount <= '0;
                    if (!i_en) begin
                        r_state <= IDLE;
                    end else if (i_rfill >= PRIME_FILL) begin
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    // Outputs lag the counters by one cycle so they line up
                    // with the FIFO data returned for this cycle's read.
                    r_de    <= w_active;
                    r_hsync <= w_hsync;
                    r_vsync <= w_vsync;
                    r_rd_d  <= w_rd;
                    if (w_active && i_empty) begin
                        r_underflow <= 1'b1;
                    end
                    // Registered one cycle early so the pulse sits at (0, V_ACTIVE).
                    r_req <= (r_hcount == H_LAST) && (r_vcount == V_REQ);
                    if (r_hcount == H_LAST) begin
                        r_hcount <= '0;
                        if (r_vcount == V_LAST) begin
                            r_vcount <= '0;
                            // Disable is honoured only at a frame boundary.
                            if (!i_en) begin
                                r_state <= IDLE;
                            end
                        end else begin
                            r_vcount <= r_vcount + 1'b1;
                        end
                    end else begin
                        r_hcount <= r_hcount + 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_req       = r_req;
    assign o_rd        = w_rd;
    assign o_hsync     = r_hsync;
    assign o_vsync     = r_vsync;
    assign o_de        = r_de;
    assign o_underflow = r_underflow;
    // A pixel whose read was skipped (underflow) goes out black.
    assign o_rgb       = (r_de && r_rd_d) ? i_rdata : '0;

endmodule

`default_nettype wire

// File: tb/tb_display_fetch.sv
// ============================================================================
// Module      : tb_display_fetch
// Description : Self-checking bench for display_fetch with reduced video
//               timing. A reference model tracks the scan position as a
//               single frame offset; expected pixels go into a scoreboard
//               queue that a separate monitor drains whenever o_de is high.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_display_fetch;

    localparam int DW = 12;
    localparam int FW = 10;
    localparam int PL = 8;
    localparam int HA = 16, HF = 4, HS = 6, HB = 4;
    localparam int VA = 12, VF = 2, VS = 2, VB = 3;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;
    localparam int HIST = 16384;

    logic          i_clk = 1'b0;
    logic          i_rstn;
    logic          i_flush;
    logic          i_en;
    logic          o_req;
    logic          o_rd;
    logic [DW-1:0] i_rdata = '0;
    logic          i_empty = 1'b1;
    logic [FW-1:0] i_rfill = '0;
    logic          o_hsync;
    logic          o_vsync;
    logic          o_de;
    logic [DW-1:0] o_rgb;
    logic          o_underflow;

    display_fetch #(
        .DATA_WIDTH (DW), .FILL_WIDTH (FW), .PRIME_LEVEL (PL),
        .H_ACTIVE (HA), .H_FRONT (HF), .H_SYNC (HS), .H_BACK (HB),
        .V_ACTIVE (VA), .V_FRONT (VF), .V_SYNC (VS), .V_BACK (VB)
    ) dut (
        .i_clk       (i_clk),
        .i_rstn      (i_rstn),
        .i_flush     (i_flush),
        .i_en        (i_en),
        .o_req       (o_req),
        .o_rd        (o_rd),
        .i_rdata     (i_rdata),
        .i_empty     (i_empty),
        .i_rfill     (i_rfill),
        .o_hsync     (o_hsync),
        .o_vsync     (o_vsync),
        .o_de        (o_de),
        .o_rgb       (o_rgb),
        .o_underflow (o_underflow)
    );

    always #5 i_clk = ~i_clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- FIFO model (drives i_rdata / i_empty / i_rfill) -------
    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] pix_hist [0:HIST-1];
    int            wr_cnt = 0;
    bit            fill_en = 1'b0;
    bit            force_empty = 1'b0;
    bit            rd_seen = 1'b0;

    always @(posedge i_clk) begin
        logic [DW-1:0] v;
        #2;
        if (rd_seen && fifo_q.size() > 0) begin
            i_rdata = fifo_q.pop_front();
        end
        if (fill_en && fifo_q.size() < 32) begin
            v = DW'($urandom);
            fifo_q.push_back(v);
            pix_hist[wr_cnt % HIST] = v;
            wr_cnt++;
        end
        i_empty = force_empty || (fifo_q.size() == 0);
        i_rfill = FW'(fifo_q.size());
    end

    // ---------------- Reference model --------------------------------------
    // mode: 0 idle, 1 priming, 2 scanning; pos = v*HT + h within the frame.
    int            m_mode = 0;
    int            m_pos = 0;
    int            m_rd_cnt = 0;
    int            m_rst_seen = 0;
    int            rst_pulses = 0;
    bit            e_de = 1'b0, e_hs = 1'b1, e_vs = 1'b1, e_req = 1'b0, e_uf = 1'b0;
    logic [DW-1:0] sb_q[$];

    always @(negedge i_clk) begin
        int            h;
        int            v;
        bit            act;
        bit            rd;
        logic [DW-1:0] px;
        rd_seen = o_rd;
        if (!i_rstn || m_rst_seen != rst_pulses) begin
            m_rst_seen = rst_pulses;
            m_mode = 0;
            m_pos  = 0;
            e_de = 1'b0; e_hs = 1'b1; e_vs = 1'b1; e_req = 1'b0; e_uf = 1'b0;
            sb_q.delete();
        end
        h   = m_pos % HT;
        v   = m_pos / HT;
        act = (m_mode == 2) && (h < HA) && (v < VA);
        rd  = act && !i_empty;
        chk("o_rd", {31'b0, o_rd}, {31'b0, rd});
        chk("o_de", {31'b0, o_de}, {31'b0, e_de});
        chk("o_hsync", {31'b0, o_hsync}, {31'b0, e_hs});
        chk("o_vsync", {31'b0, o_vsync}, {31'b0, e_vs});
        chk("o_req", {31'b0, o_req}, {31'b0, e_req});
        chk("o_underflow", {31'b0, o_underflow}, {31'b0, e_uf});
        if (i_rstn) begin
            px = '0;
            if (rd) begin
                px = pix_hist[m_rd_cnt % HIST];
                m_rd_cnt++;
            end
            if (i_flush) begin
                m_mode = 0;
                m_pos  = 0;
                e_de = 1'b0; e_hs = 1'b1; e_vs = 1'b1; e_req = 1'b0; e_uf = 1'b0;
            end else begin
                e_de = 1'b0; e_hs = 1'b1; e_vs = 1'b1; e_req = 1'b0;
                case (m_mode)
                    0: if (i_en) begin
                        m_mode = 1;
                        e_req  = 1'b1;
                    end
                    1: if (!i_en) begin
                        m_mode = 0;
                    end else if (int'(i_rfill) >= PL) begin
                        m_mode = 2;
                        m_pos  = 0;
                    end
                    default: begin
                        e_de = act;
                        e_hs = !(h >= HA + HF && h < HA + HF + HS);
                        e_vs = !(v >= VA + VF && v < VA + VF + VS);
                        if (act && i_empty) e_uf = 1'b1;
                        if (act) sb_q.push_back(px);
                        if (m_pos == FRAME - 1) begin
                            m_pos = 0;
                            if (!i_en) m_mode = 0;
                        end else begin
                            m_pos++;
                        end
                        e_req = (m_mode == 2) && (m_pos == HT * VA);
                    end
                endcase
            end
        end
    end

    // ---------------- Pixel monitor -----------------------------------------
    always @(negedge i_clk) begin
        logic [DW-1:0] exp_px;
        if (o_de) begin
            if (sb_q.size() == 0) begin
                chk("rgb_unexpected_de", {31'b0, o_de}, 32'd0);
            end else begin
                exp_px = sb_q.pop_front();
                chk("o_rgb", {20'b0, o_rgb}, {20'b0, exp_px});
            end
        end else begin
            chk("o_rgb_blank", {20'b0, o_rgb}, 32'd0);
        end
    end

    // ---------------- Stimulus ----------------------------------------------
    task automatic step(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    task automatic wait_pos(input int target, input int budget, input string nm);
        int n   = 0;
        bit hit = 1'b0;
        while (!hit && n < budget) begin
            @(posedge i_clk);
            #1;
            n++;
            if (m_mode == 2 && m_pos == target) hit = 1'b1;
        end
        chk(nm, {31'b0, hit}, 32'd1);
    endtask

    initial begin
        i_rstn  = 1'b0;
        i_flush = 1'b0;
        i_en    = 1'b0;
        step(3);
        i_rstn = 1'b1;
        step(5);

        // Enable with an empty FIFO: priming must wait for the fill level.
        i_en = 1'b1;
        step(10);
        fill_en = 1'b1;
        wait_pos(0, 100, "timeout_run_entry");

        // Five starved active pixels on line 10.
        wait_pos(10 * HT + 3, 2 * FRAME, "timeout_line10");
        force_empty = 1'b1;
        step(5);
        force_empty = 1'b0;
        step(2);
        chk("underflow_sticky", {31'b0, o_underflow}, 32'd1);

        // Flush mid-line in the next frame, with enable dropped.
        wait_pos(2 * HT + 10, 2 * FRAME, "timeout_flush_point");
        i_flush = 1'b1;
        i_en    = 1'b0;
        step(1);
        i_flush = 1'b0;
        chk("flush_hsync", {31'b0, o_hsync}, 32'd1);
        chk("flush_underflow", {31'b0, o_underflow}, 32'd0);
        step(50);

        // Enable dropped at line 5: frame completes, then idle.
        i_en = 1'b1;
        wait_pos(5 * HT, 3 * FRAME, "timeout_line5");
        i_en = 1'b0;
        step(FRAME + 1000);

        // Randomized phase: starvation, enable toggling, fill stalls.
        i_en = 1'b1;
        repeat (4 * FRAME) begin
            step(1);
            force_empty = ($urandom % 16) == 0;
            fill_en     = ($urandom % 8) != 0;
            if (($urandom % 200) == 0) i_en = ~i_en;
        end
        force_empty = 1'b0;
        fill_en     = 1'b1;
        i_en        = 1'b1;

        // Asynchronous reset pulse between clock edges in an active line.
        wait_pos(3 * HT + 5, 3 * FRAME, "timeout_reset_point");
        #1 i_rstn = 1'b0;
        #1;
        chk("async_de", {31'b0, o_de}, 32'd0);
        chk("async_hsync", {31'b0, o_hsync}, 32'd1);
        chk("async_vsync", {31'b0, o_vsync}, 32'd1);
        chk("async_rgb", {20'b0, o_rgb}, 32'd0);
        chk("async_rd", {31'b0, o_rd}, 32'd0);
        chk("async_req", {31'b0, o_req}, 32'd0);
        chk("async_underflow", {31'b0, o_underflow}, 32'd0);
        #1;
        i_en = 1'b0;
        rst_pulses++;
        i_rstn = 1'b1;
        step(20);
        i_en = 1'b1;
        step(FRAME + 50);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
